// File: rtl/sort_pkg.sv
// Shared definitions for the 4-lane bitonic sort path (loader and network).
package sort_pkg;

    // Lane count of the sort network this loader feeds.
    localparam int LANES = 4;

    // Widest key that pad_word can build; callers keep the low W bits.
    localparam int PAD_W_MAX = 64;

    // Lane count value: 0..LANES real lanes in a frame.
    typedef logic [$clog2(LANES+1)-1:0] lane_cnt_t;

    // Fill FSM states: FILL accepts keys, HELD parks a finished frame
    // while the output register is still occupied.
    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } fill_state_t;

    // Pad key for unused lanes: all-ones sorts to the top of an ascending
    // sort, all-zeros to the bottom. Only the low w bits are set.
    function automatic logic [PAD_W_MAX-1:0] pad_word(input int w, input bit pad_max);
        logic [PAD_W_MAX-1:0] p;
        p = '0;
        for (int i = 0; i < PAD_W_MAX; i++) begin
            if (i < w) p[i] = pad_max;
        end
        return p;
    endfunction

endpackage

// File: rtl/sort_frame_reg.sv
// Output holding register for one frame, valid/ready on both sides.
module sort_frame_reg #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [N-1:0][W-1:0] load_data,
    input  logic [CW-1:0]       load_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*W-1:0]      out_data,
    output logic [CW-1:0]       out_count
);

    // A load is possible when empty or when the current frame drains on
    // this same edge, which gives full throughput with out_ready held high.
    assign load_ready = !out_valid || out_ready;

    // Load a new frame, otherwise clear valid on drain; hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load_valid && load_ready) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bitonic_sort_loader_4.sv
// Serial-to-frame loader: packs keys into N-lane frames, pads short frames
// closed by in_last, and hands them to the sort network via sort_frame_reg.
module bitonic_sort_loader_4
    import sort_pkg::*;
#(
    parameter int W       = 8,
    parameter int N       = LANES,
    parameter int PAD_MAX = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out_data,
    output logic [$clog2(N+1)-1:0]   out_count
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);
    localparam logic [PAD_W_MAX-1:0] PAD_FULL = pad_word(W, PAD_MAX != 0);
    localparam logic [W-1:0]         PAD      = PAD_FULL[W-1:0];

    fill_state_t          state, state_nxt;
    logic [IW-1:0]        idx;
    logic [N-1:0][W-1:0]  fill_buf;
    logic [N-1:0][W-1:0]  frame;
    logic [CW-1:0]        frame_cnt;
    logic [CW-1:0]        held_cnt;
    logic                 in_xfer;
    logic                 close;
    logic                 load_valid;
    logic                 load_ready;
    logic [N-1:0][W-1:0]  load_data;
    logic [CW-1:0]        load_cnt;

    // Ready depends on state only; forced low during the reset cycle.
    assign in_ready  = (state == FILL) && rst_n;
    assign in_xfer   = in_valid && in_ready;
    assign close     = in_xfer && (in_last || (idx == IW'(N-1)));
    assign frame_cnt = CW'(idx) + CW'(1);

    // Closing frame: stored lanes below idx, the incoming key at idx, pad above.
    always_comb begin
        frame = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(idx))       frame[i] = fill_buf[i];
            else if (i == int'(idx)) frame[i] = in_data;
            else                     frame[i] = PAD;
        end
    end

    // In HELD the parked frame lives in fill_buf; otherwise load straight
    // from the closing key so the output sees it one cycle later.
    assign load_valid = close || (state == HELD);
    assign load_data  = (state == HELD) ? fill_buf : frame;
    assign load_cnt   = (state == HELD) ? held_cnt : frame_cnt;

    // Fill state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Park a frame that cannot load; release it when the output drains.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (close && !load_ready) state_nxt = HELD;
            HELD:    if (load_ready)           state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Lane writes and index; a closing key stores the whole padded frame
    // so it can be parked if the output is busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            fill_buf <= '0;
            held_cnt <= '0;
        end else if (close) begin
            idx      <= '0;
            fill_buf <= frame;
            held_cnt <= frame_cnt;
        end else if (in_xfer) begin
            idx           <= idx + IW'(1);
            fill_buf[idx] <= in_data;
        end
    end

    sort_frame_reg #(
        .W  (W),
        .N  (N),
        .CW (CW)
    ) u_frame_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_count (load_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count)
    );

endmodule
